// File: rtl/tetris_vga_pkg.sv
// Shared geometry, colour and state definitions for the Tetris board renderer.
package tetris_vga_pkg;
   localparam int CELL_PX    = 16;
   localparam int BOARD_W    = 10;
   localparam int BOARD_H    = 20;
   localparam int NUM_CELLS  = BOARD_W * BOARD_H;
   localparam int BOARD_W_PX = BOARD_W * CELL_PX;
   localparam int BOARD_H_PX = BOARD_H * CELL_PX;
   localparam int CIDX_W     = 3;
   localparam int ADDR_W     = 8;

   typedef logic [CIDX_W-1:0] cidx_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [11:0]       pix_t;

   typedef enum logic {S_IDLE, S_CLEAR} clr_state_e;

   function automatic pix_t palette(cidx_t c);
      pix_t p;
      case (c)
         3'd1:    p = 12'hFF0;
         3'd2:    p = 12'hF00;
         3'd3:    p = 12'h0AF;
         3'd4:    p = 12'h0FF;
         3'd5:    p = 12'h0F0;
         3'd6:    p = 12'hF0A;
         3'd7:    p = 12'h00F;
         default: p = 12'h000;
      endcase
      return p;
   endfunction

   // y*10 + x built from shifts so no multiplier is inferred
   function automatic addr_t cell_index(logic [4:0] y, logic [3:0] x);
      return ({3'b000, y} << 3) + ({3'b000, y} << 1) + {4'b0000, x};
   endfunction
endpackage

// File: rtl/tetris_board_pixel_gen_if.sv
// VGA read-request and game-logic write bundle for the board pixel generator.
interface tetris_board_pixel_gen_if;
   logic [8:0]  row;
   logic [9:0]  col;
   logic        rdn;
   logic [11:0] Din;
   logic        frame_start;
   logic        wr_en;
   logic [3:0]  wr_x;
   logic [4:0]  wr_y;
   logic [2:0]  wr_color;
   logic        clr_req;
   logic        busy;

   modport master (
      output row, col, rdn, wr_en, wr_x, wr_y, wr_color, clr_req,
      input  Din, frame_start, busy
   );
   modport slave (
      input  row, col, rdn, wr_en, wr_x, wr_y, wr_color, clr_req,
      output Din, frame_start, busy
   );
endinterface

// File: rtl/tetris_cell_ram.sv
// 200x3 cell store: one synchronous write port, one asynchronous read port.
module tetris_cell_ram
   import tetris_vga_pkg::*;
(
   input  logic  clk,
   input  logic  we,
   input  addr_t waddr,
   input  cidx_t wdata,
   input  addr_t raddr,
   output cidx_t rdata
);
   cidx_t mem_q [NUM_CELLS];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/tetris_board_pixel_gen.sv
// Board pixel generator: coordinate mapping, clear FSM, pixel mux, output register.
module tetris_board_pixel_gen
   import tetris_vga_pkg::*;
#(
   parameter int   BOARD_X0    = 240,
   parameter int   BOARD_Y0    = 80,
   parameter int   FRAME_W     = 2,
   parameter pix_t BG_COLOR    = 12'h000,
   parameter pix_t FRAME_COLOR = 12'hFFF,
   parameter pix_t EMPTY_COLOR = 12'h222
) (
   input logic                      clk,
   input logic                      rst,
   tetris_board_pixel_gen_if.slave  bus
);
   clr_state_e state_q, state_d;
   addr_t      ptr_q, ptr_d;
   pix_t       din_q, din_d;
   logic       fs_q, fs_d;

   logic [11:0] dx, ex;
   logic [10:0] dy, ey;
   logic        in_board, in_frame, shade, wr_ok, clearing;
   addr_t       raddr, waddr;
   cidx_t       rdata, wdata;
   pix_t        cell_pix;
   logic        we;

   // Offsets go negative left/above the board; the sign bit rejects them
   always_comb begin
      dx = {2'b00, bus.col} - 12'(BOARD_X0);
      dy = {2'b00, bus.row} - 11'(BOARD_Y0);
      ex = dx + 12'(FRAME_W);
      ey = dy + 11'(FRAME_W);
      in_board = !dx[11] && dx < 12'(BOARD_W_PX)
              && !dy[10] && dy < 11'(BOARD_H_PX);
      in_frame = !ex[11] && ex < 12'(BOARD_W_PX + 2*FRAME_W)
              && !ey[10] && ey < 11'(BOARD_H_PX + 2*FRAME_W);
      raddr = in_board ? cell_index(dy[8:4], dx[7:4]) : '0;
      shade = (dx[3:0] == 4'hF) || (dy[3:0] == 4'hF);
   end

   always_comb begin
      clearing = (state_q == S_CLEAR);
      wr_ok = bus.wr_en && (bus.wr_x < 4'(BOARD_W))
           && (bus.wr_y < 5'(BOARD_H));
      we    = clearing || wr_ok;
      waddr = clearing ? ptr_q : cell_index(bus.wr_y, bus.wr_x);
      wdata = clearing ? '0 : bus.wr_color;
   end

   tetris_cell_ram u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.clr_req) begin
               state_d = S_CLEAR;
               ptr_d   = '0;
            end
         end
         S_CLEAR: begin
            if (ptr_q == addr_t'(NUM_CELLS - 1)) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cell_pix = (rdata == '0) ? EMPTY_COLOR : palette(rdata);
      din_d    = BG_COLOR;
      if (bus.rdn) begin
         din_d = '0;
      end else if (in_board) begin
         din_d = shade ? ((cell_pix >> 1) & 12'h777) : cell_pix;
      end else if (in_frame) begin
         din_d = FRAME_COLOR;
      end
      fs_d = !bus.rdn && (bus.row == '0) && (bus.col == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
         din_q   <= '0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         din_q   <= din_d;
         fs_q    <= fs_d;
      end
   end

   assign bus.Din         = din_q;
   assign bus.frame_start = fs_q;
   assign bus.busy        = (state_q == S_CLEAR);
endmodule
